// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter: one bit-serial full-adder cell shared by two requesters
// through a round-robin arbiter. Each accepted operand pair is summed LSB first,
// one bit per clock, and the result is returned on a valid/ready port with the ID
// of the requester that issued it.
module serial_adder_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    input  logic             res_ready
);

    // The bit counter must hold values 0..WIDTH-1. Sizing it from WIDTH+1 keeps
    // it at least 1 bit wide when WIDTH is 1.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             cout_q, cout_d;

    logic             grant0, grant1;
    logic             fa_sum, fa_carry;

    // Round-robin grant. A lone requester always wins. On a tie the grant goes
    // to the requester that was not served last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;

    // The single shared full-adder cell works on the current LSBs.
    always_comb begin
        fa_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_carry = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence and its datapath.
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        sum_sr_d     = sum_sr_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cout_d       = cout_q;
        unique case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    a_sr_d       = req1_ready ? req1_a : req0_a;
                    b_sr_d       = req1_ready ? req1_b : req0_b;
                    carry_d      = 1'b0;
                    cnt_d        = '0;
                    id_d         = req1_ready;
                    last_grant_d = req1_ready;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                // The sum enters at the MSB and moves right. After WIDTH shifts,
                // bit 0 of the sum sits at the LSB.
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            sum_sr_q     <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            sum_sr_q     <= sum_sr_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cout_q       <= cout_d;
        end
    end

    // All result outputs come directly from flops. They stay frozen in DONE and
    // after the handshake, because nothing shifts outside SHIFT.
    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_sr_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Testbench for serial_adder_arbiter (WIDTH=8). It applies directed vectors,
// hand-written multi-cycle corner sequences, and a randomized phase that is
// compared every cycle against a transaction-level reference model.
module tb_serial_adder_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         res_valid;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id;
    logic         res_ready;

    int checks   = 0;
    int failures = 0;

    serial_adder_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_ready(req1_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_res_valid"}, 32'(res_valid), 0);
        chk({name, "_res_sum"},   32'(res_sum),   0);
        chk({name, "_res_cout"},  32'(res_cout),  0);
        chk({name, "_res_id"},    32'(res_id),    0);
    endtask

    // Issues one operation on requester id. The result port stays ready. The
    // task checks the latency, the sum, the carry and the ID.
    task automatic do_op(input string name, input logic id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] esum, input logic ecout);
        int  lat;
        bit  got;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        got = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) begin
            chk({name, "_accept_timeout"}, 0, 1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 0; got = 0;
        for (int t = 0; t < 30; t++) begin
            if (res_valid === 1'b1) begin got = 1; break; end
            lat++;
            @(negedge clk);
        end
        chk({name, "_latency"}, lat, W);
        chk({name, "_sum"},  32'(res_sum),  32'(esum));
        chk({name, "_cout"}, 32'(res_cout), 32'(ecout));
        chk({name, "_id"},   32'(res_id),   32'(id));
        @(negedge clk);
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] a, b;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[6];

    // Reference-model state for the randomized phase.
    int           m_phase;   // 0 idle, 1 adding, 2 result pending
    int           m_cnt;
    logic         m_last, m_id;
    logic [W:0]   m_total;
    bit           p0, p1;
    logic         g0, g1;

    initial begin
        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};

        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("novalid_r0", 32'(req0_ready), 0);
        chk("novalid_r1", 32'(req1_ready), 0);
        req0_valid = 1'b1; #1;
        chk("solo0_r0", 32'(req0_ready), 1);
        chk("solo0_r1", 32'(req1_ready), 0);
        req1_valid = 1'b1; #1;
        chk("tie_r0", 32'(req0_ready), 1);
        chk("tie_r1", 32'(req1_ready), 0);
        req0_valid = 1'b0; #1;
        chk("solo1_r1", 32'(req1_ready), 1);
        req1_valid = 1'b0;

        // Directed operand vectors.
        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);

        // Both requesters stay valid, so the grants alternate every W+2 cycles.
        begin
            int   cyc, n, prev;
            logic ids[$];
            int   at[$];
            reset_dut();
            @(negedge clk);
            req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
            req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04;
            for (cyc = 0; cyc < 45; cyc++) begin
                #1;
                if (req0_ready && req1_ready) chk("alt_both_ready", 1, 0);
                if (req0_ready) begin ids.push_back(1'b0); at.push_back(cyc); end
                if (req1_ready) begin ids.push_back(1'b1); at.push_back(cyc); end
                @(negedge clk);
            end
            req0_valid = 0; req1_valid = 0;
            chk("alt_count", ids.size(), 5);
            n = (ids.size() < 4) ? ids.size() : 4;
            prev = 0;
            for (int k = 0; k < n; k++) begin
                chk($sformatf("alt_id%0d", k), 32'(ids[k]), 32'(k % 2));
                if (k > 0) chk($sformatf("alt_gap%0d", k), at[k] - prev, W + 2);
                prev = at[k];
            end
            repeat (12) @(negedge clk);
        end

        // A stalled result holds its outputs, and the next accept follows the handshake.
        begin
            bit got;
            reset_dut();
            res_ready = 1'b0;
            @(negedge clk);
            req0_valid = 1; req0_a = 8'hA5; req0_b = 8'h6B;
            #1 chk("stall_acc", 32'(req0_ready), 1);
            @(negedge clk);
            req0_valid = 0;
            req1_valid = 1; req1_a = 8'h10; req1_b = 8'h20;
            got = 0;
            for (int t = 0; t < 20; t++) begin
                if (res_valid) begin got = 1; break; end
                @(negedge clk);
            end
            chk("stall_reached", 32'(got), 1);
            for (int t = 0; t < 5; t++) begin
                #1;
                chk("stall_valid", 32'(res_valid), 1);
                chk("stall_sum",   32'(res_sum),   32'h10);
                chk("stall_cout",  32'(res_cout),  1);
                chk("stall_id",    32'(res_id),    0);
                chk("stall_rdy",   32'({req0_ready, req1_ready}), 0);
                @(negedge clk);
            end
            res_ready = 1'b1;
            @(negedge clk); #1;
            chk("stall_after_valid", 32'(res_valid), 0);
            chk("stall_next_accept", 32'(req1_ready), 1);
            @(negedge clk);
            req1_valid = 0;
            repeat (12) @(negedge clk);
        end

        // A reset during the add discards the operation.
        begin
            int seen;
            @(negedge clk);
            req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22;
            #1 chk("rst_acc", 32'(req0_ready), 1);
            @(negedge clk);
            req0_valid = 0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0; #1;
            chk_idle_outputs("midrst");
            @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            for (int t = 0; t < 15; t++) begin
                if (res_valid) seen++;
                @(negedge clk);
            end
            chk("midrst_no_result", seen, 0);
            do_op("postrst", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0);
        end

        // Randomized traffic checked against the transaction-level model.
        reset_dut();
        m_phase = 0; m_last = 1'b1; m_cnt = 0; m_id = 0; m_total = '0;
        p0 = 0; p1 = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1; req0_a = W'($urandom); req0_b = W'($urandom);
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1; req1_a = W'($urandom); req1_b = W'($urandom);
            end
            req0_valid = p0; req1_valid = p1;
            res_ready  = ($urandom_range(0, 9) < 7);
            #1;
            g0 = 0; g1 = 0;
            if (m_phase == 0) begin
                if (p0 && p1) begin g0 = m_last; g1 = ~m_last; end
                else begin g0 = p0; g1 = p1; end
            end
            chk("rnd_r0", 32'(req0_ready), 32'(g0));
            chk("rnd_r1", 32'(req1_ready), 32'(g1));
            chk("rnd_valid", 32'(res_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("rnd_sum",  32'(res_sum),  32'(m_total[W-1:0]));
                chk("rnd_cout", 32'(res_cout), 32'(m_total[W]));
                chk("rnd_id",   32'(res_id),   32'(m_id));
            end
            // Advance the model to the state after the coming rising edge.
            if (m_phase == 0 && (g0 || g1)) begin
                m_id    = g1;
                m_last  = g1;
                m_total = g1 ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
                m_cnt   = W;
                m_phase = 1;
                if (g1) p1 = 0; else p0 = 0;
            end else if (m_phase == 1) begin
                m_cnt--;
                if (m_cnt == 0) m_phase = 2;
            end else if (m_phase == 2 && res_ready) begin
                m_phase = 0;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic reset_dut();
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; res_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

endmodule
